mem_arbiter: RTL and testbench

Sequential arbiter that shares the single multicycle main memory between the instruction cache and the data cache. It grants ownership for a whole miss transaction (block fill or write-through), tracks in-flight reads so ownership never changes while data is still returning, and steers `data_valid` back to the owning cache. It sits between the two cache miss FSMs and the memory, and replaces the combinational "iCache busy wins" select in the memory top level.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - iCache/dCache arbiter for the shared multicycle main memory.
// Optional ARB_ROUND_ROBIN_EN selects round-robin instead of fixed iCache-first priority.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_busy,
    input  logic        i_read_req,
    input  logic [15:0] i_addr,
    input  logic        d_busy,
    input  logic        d_read_req,
    input  logic        d_wrt_mem,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        mem_valid,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        i_ack,
    output logic        d_ack,
    output logic        i_data_vld,
    output logic        d_data_vld,
    output logic        grant_i,
    output logic        grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_pick;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_out_nxt;
    logic               r_grant_i;
    logic               r_grant_d;
    logic               w_ok_rd;
    logic               w_rd_acc;
    logic               w_dec;
    logic               w_owner_busy;
    logic               w_release;
    logic               w_prefer_i;
    logic               w_mem_en;
    logic               w_mem_wr;
    logic [15:0]        w_mem_addr;
    logic [15:0]        w_mem_wdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic               r_last_d;
    // From IDLE the side that did not own last wins; on release the other side wins.
    assign w_prefer_i = (r_state == IDLE) ? r_last_d : (r_state == OWN_D);
`else
    assign w_prefer_i = 1'b1;
`endif

    assign w_ok_rd = (r_outstanding < CNT_W'(MAX_OUT));

    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_mem_wdata = 16'h0000;
        case (r_state)
            OWN_I: begin
                w_mem_en   = i_read_req & w_ok_rd;
                w_mem_addr = i_addr;
            end
            OWN_D: begin
                // Writes bypass the read-credit limit; they return no data.
                w_mem_en    = d_wrt_mem | (d_read_req & w_ok_rd);
                w_mem_wr    = d_wrt_mem;
                w_mem_addr  = d_addr;
                w_mem_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign w_rd_acc = w_mem_en & ~w_mem_wr;
    assign w_dec    = mem_valid & (r_outstanding != '0);

    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_rd_acc && !w_dec)
            w_out_nxt = r_outstanding + 1'b1;
        else if (!w_rd_acc && w_dec)
            w_out_nxt = r_outstanding - 1'b1;
    end

    always_comb begin
        w_owner_busy = 1'b0;
        if (r_state == OWN_I)
            w_owner_busy = i_busy;
        else if (r_state == OWN_D)
            w_owner_busy = d_busy;
    end

    assign w_release = (r_state != IDLE) && !w_owner_busy && (w_out_nxt == '0);

    always_comb begin
        w_pick = IDLE;
        if (i_busy && (w_prefer_i || !d_busy))
            w_pick = OWN_I;
        else if (d_busy)
            w_pick = OWN_D;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE || w_release)
            w_next = w_pick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_outstanding <= '0;
            r_grant_i     <= 1'b0;
            r_grant_d     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d      <= 1'b1;
`endif
        end else begin
            r_state       <= w_next;
            r_outstanding <= w_out_nxt;
            r_grant_i     <= (w_next == OWN_I);
            r_grant_d     <= (w_next == OWN_D);
`ifdef ARB_ROUND_ROBIN_EN
            if (w_next == OWN_I)
                r_last_d <= 1'b0;
            else if (w_next == OWN_D)
                r_last_d <= 1'b1;
`endif
        end
    end

    assign mem_en     = w_mem_en;
    assign mem_wr     = w_mem_wr;
    assign mem_addr   = w_mem_addr;
    assign mem_wdata  = w_mem_wdata;
    assign i_ack      = w_mem_en & r_grant_i;
    assign d_ack      = w_mem_en & r_grant_d;
    assign i_data_vld = mem_valid & r_grant_i;
    assign d_data_vld = mem_valid & r_grant_d;
    assign grant_i    = r_grant_i;
    assign grant_d    = r_grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_busy, i_read_req;
    logic [15:0] i_addr;
    logic        d_busy, d_read_req, d_wrt_mem;
    logic [15:0] d_addr, d_wdata;
    logic        mem_valid;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic        i_ack, d_ack, i_data_vld, d_data_vld, grant_i, grant_d;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.MAX_OUT(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_busy     (i_busy),
        .i_read_req (i_read_req),
        .i_addr     (i_addr),
        .d_busy     (d_busy),
        .d_read_req (d_read_req),
        .d_wrt_mem  (d_wrt_mem),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .mem_valid  (mem_valid),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .i_ack      (i_ack),
        .d_ack      (d_ack),
        .i_data_vld (i_data_vld),
        .d_data_vld (d_data_vld),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits: {mem_en, mem_wr, i_ack, d_ack, i_data_vld, d_data_vld, grant_i, grant_d}
    task automatic vec(input string tag, input logic [7:0] exp, input int exp_addr);
        @(negedge clk);
        check_eq(tag, {24'd0, mem_en, mem_wr, i_ack, d_ack, i_data_vld, d_data_vld, grant_i, grant_d},
                 {24'd0, exp});
        if (exp_addr >= 0)
            check_eq({tag, "_addr"}, {16'd0, mem_addr}, exp_addr);
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] EXP_TIE1 =
`ifdef ARB_ROUND_ROBIN_EN
        8'h01;
`else
        8'h02;
`endif

    initial begin
        rst = 1'b1;
        i_busy = 1'b0; i_read_req = 1'b0; i_addr = 16'h0;
        d_busy = 1'b0; d_read_req = 1'b0; d_wrt_mem = 1'b0;
        d_addr = 16'h0; d_wdata = 16'h0; mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vec("rst_out", 8'h00, -1);

        // Reset in the middle of a dCache transaction with 3 reads in flight
        d_busy = 1'b1;
        vec("d_idle", 8'h00, -1);
        d_read_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_addr = 16'h3000 + 16'(2 * k);
            vec("d_rd_pre", 8'h91, 32'h3000 + 2 * k);
        end
        rst = 1'b1; d_read_req = 1'b0;
        vec("d_pre_rst", 8'h01, -1);
        rst = 1'b0; d_busy = 1'b0; mem_valid = 1'b1;
        vec("post_rst_mv", 8'h00, -1);
        mem_valid = 1'b0;

        // iCache block fill, 8 reads with credit stalls
        i_busy = 1'b1;
        vec("i_idle", 8'h00, -1);
        i_read_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i_addr = 16'h0100 + 16'(2 * k);
            vec("i_rd", 8'hA2, 32'h0100 + 2 * k);
        end
        i_addr = 16'h0108;
        vec("i_stall0", 8'h02, -1);
        mem_valid = 1'b1;
        vec("i_stall1", 8'h0A, -1);
        vec("i_incdec", 8'hAA, 32'h0108);
        mem_valid = 1'b0;
        i_addr = 16'h010A;
        vec("i_rd5", 8'hA2, 32'h010A);
        i_addr = 16'h010C;
        vec("i_stall2", 8'h02, -1);
        mem_valid = 1'b1;
        vec("i_stall3", 8'h0A, -1);
        mem_valid = 1'b0;
        vec("i_rd6", 8'hA2, 32'h010C);
        i_addr = 16'h010E; mem_valid = 1'b1;
        vec("i_stall4", 8'h0A, -1);
        mem_valid = 1'b0;
        vec("i_rd7", 8'hA2, 32'h010E);
        i_read_req = 1'b0; mem_valid = 1'b1;
        vec("i_dv5", 8'h0A, -1);
        d_busy = 1'b1;
        vec("i_dv6", 8'h0A, -1);

        // Late data: busy gone with 2 reads in flight; dCache waits as non-owner
        i_busy = 1'b0; mem_valid = 1'b0; d_read_req = 1'b1; d_addr = 16'h3000;
        vec("late0", 8'h02, -1);
        mem_valid = 1'b1;
        vec("late1", 8'h0A, -1);
        mem_valid = 1'b0;
        vec("late2", 8'h02, -1);
        mem_valid = 1'b1;
        vec("late3", 8'h0A, -1);
        mem_valid = 1'b0;

        // Back-to-back handoff, write-through in the first dCache cycle
        d_read_req = 1'b0; d_wrt_mem = 1'b1; d_addr = 16'h2000; d_wdata = 16'hBEEF;
        @(negedge clk);
        check_eq("d_wr_vec", {24'd0, mem_en, mem_wr, i_ack, d_ack, i_data_vld, d_data_vld, grant_i, grant_d},
                 32'h000000D1);
        check_eq("d_wr_addr", {16'd0, mem_addr}, 32'h2000);
        check_eq("d_wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        @(posedge clk);
        #1;
        d_wrt_mem = 1'b0; d_busy = 1'b0;
        vec("d_rel", 8'h01, -1);
        mem_valid = 1'b1;
        vec("idle_mv", 8'h00, -1);
        mem_valid = 1'b0;

        // Counter must still be 0: four reads accepted, fifth stalls
        d_busy = 1'b1;
        vec("d_idle2", 8'h00, -1);
        d_read_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_addr = 16'h4000 + 16'(2 * k);
            vec("d_rd", 8'h91, 32'h4000 + 2 * k);
        end
        vec("d_stall", 8'h01, -1);
        d_read_req = 1'b0; mem_valid = 1'b1;
        for (int k = 0; k < 3; k++)
            vec("d_dv", 8'h05, -1);
        d_busy = 1'b0;
        vec("d_dv_last", 8'h05, -1);
        mem_valid = 1'b0;

        // Ties in IDLE: first after a D transaction, then after an I transaction
        i_busy = 1'b1; d_busy = 1'b1;
        vec("tie0_idle", 8'h00, -1);
        i_busy = 1'b0; d_busy = 1'b0;
        vec("tie0_own", 8'h02, -1);
        i_busy = 1'b1; d_busy = 1'b1;
        vec("tie1_idle", 8'h00, -1);
        vec("tie1_own", EXP_TIE1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
